keccak_sched: RTL



---
 rtl/keccak_sched_pkg.sv | 14 +
 rtl/keccak_rr_arb.sv | 31 +++
 rtl/keccak_sched.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/keccak_sched_pkg.sv
// Shared types and constants for the Keccak permutation scheduler.
package keccak_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_DONE
  } sched_state_e;

  localparam int unsigned KECCAK_NUM_ROUNDS = 24;
  localparam int unsigned KECCAK_RND_W      = 5;

endpackage

// File: rtl/keccak_rr_arb.sv
// Combinational round-robin pick: lowest index at or above ptr_i wins,
// wrapping from NUM_REQ-1 back to 0.
module keccak_rr_arb #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDW     = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDW-1:0]     idx_o,
  output logic               valid_o
);

  logic [IDW-1:0] cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IDW'((32'(ptr_i) + i) % NUM_REQ);
      if (!valid_o && req_i[cand]) begin
        valid_o     = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/keccak_sched.sv
// Round-robin scheduler for a shared Keccak-f[1600] datapath.
// Optional completed-permutation counter enabled by KECCAK_SCHED_PERF_EN.
module keccak_sched
  import keccak_sched_pkg::*;
#(
  parameter  int unsigned NUM_REQ    = 2,
  parameter  int unsigned NUM_ROUNDS = KECCAK_NUM_ROUNDS,
  localparam int unsigned IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_REQ-1:0]      req_i,
  output logic [NUM_REQ-1:0]      gnt_o,
  output logic [NUM_REQ-1:0]      done_o,
  input  logic                    ready_dp_i,
  output logic                    start_dp_o,
  output logic [KECCAK_RND_W-1:0] round_o,
  output logic [IDW-1:0]          owner_o,
  output logic                    busy_o,
  output logic                    irq_o,
  output logic [31:0]             perf_cnt_o
);

  localparam logic [KECCAK_RND_W-1:0] RND_LAST = KECCAK_RND_W'(NUM_ROUNDS - 1);
  localparam logic [IDW-1:0]          OWN_LAST = IDW'(NUM_REQ - 1);

  sched_state_e              state_q, state_d;
  logic [IDW-1:0]            owner_q, owner_d;
  logic [NUM_REQ-1:0]        owner_oh_q, owner_oh_d;
  logic [IDW-1:0]            ptr_q, ptr_d;
  logic [KECCAK_RND_W-1:0]   rnd_q, rnd_d;

  logic [NUM_REQ-1:0]        arb_oh;
  logic [IDW-1:0]            arb_idx;
  logic                      arb_valid;

  keccak_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_oh),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      owner_oh_q <= '0;
      ptr_q      <= '0;
      rnd_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      owner_oh_q <= owner_oh_d;
      ptr_q      <= ptr_d;
      rnd_q      <= rnd_d;
    end
  end

  // Owner is kept both as an index (owner_o, ptr rotation) and one-hot
  // (grant/done decode), both captured from the arbiter in the same cycle.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    owner_oh_d = owner_oh_q;
    ptr_d      = ptr_q;
    rnd_d      = rnd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid && ready_dp_i) begin
          owner_d    = arb_idx;
          owner_oh_d = arb_oh;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        rnd_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (rnd_q == RND_LAST) begin
          rnd_d   = '0;
          state_d = ST_DONE;
        end else begin
          rnd_d = rnd_q + KECCAK_RND_W'(1);
        end
      end
      ST_DONE: begin
        ptr_d   = (owner_q == OWN_LAST) ? '0 : owner_q + IDW'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_o      = '0;
    done_o     = '0;
    start_dp_o = 1'b0;
    round_o    = '0;
    busy_o     = 1'b0;
    irq_o      = 1'b0;
    unique case (state_q)
      ST_START: begin
        gnt_o      = owner_oh_q;
        start_dp_o = 1'b1;
        busy_o     = 1'b1;
      end
      ST_RUN: begin
        gnt_o   = owner_oh_q;
        round_o = rnd_q;
        busy_o  = 1'b1;
      end
      ST_DONE: begin
        done_o = owner_oh_q;
        irq_o  = 1'b1;
        busy_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign owner_o = owner_q;

`ifdef KECCAK_SCHED_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (state_q == ST_DONE) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign perf_cnt_o = perf_q;
`else
  assign perf_cnt_o = '0;
`endif

endmodule
